fpu_dispatch: RTL

In-order dispatcher and result arbiter for the FPU execution units (adder, multiplier, div/sqrt, sign modifier, misc).
- Takes one op per cycle from the FPU issue stage and steers the valid/ready handshake to the owning unit.
- Records the unit ID in an order FIFO.
- Returns results strictly in issue order through a single valid/ready output, even though unit latencies differ.

---
 rtl/fpu_dispatch_pkg.sv | 56 +++++
 rtl/fpu_dispatch_order_fifo.sv | 72 +++++++
 rtl/fpu_dispatch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fpu_dispatch_pkg.sv
//------------------------------------------------------------------------------
// FPU_pkg : unit IDs, FPU opcodes and the opcode->unit steering function.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package FPU_pkg;

    localparam int N_FPU_UNITS = 5;

    typedef enum logic [2:0] {
        FPU_UNIT_ADD     = 3'd0,
        FPU_UNIT_MUL     = 3'd1,
        FPU_UNIT_DIVSQRT = 3'd2,
        FPU_UNIT_SGN     = 3'd3,
        FPU_UNIT_MISC    = 3'd4,
        FPU_UNIT_NONE    = 3'd5
    } fpu_unit_t;

    localparam logic [4:0] FPU_OP_ADD     = 5'd0;
    localparam logic [4:0] FPU_OP_SUB     = 5'd1;
    localparam logic [4:0] FPU_OP_MUL     = 5'd2;
    localparam logic [4:0] FPU_OP_DIV     = 5'd3;
    localparam logic [4:0] FPU_OP_SQRT    = 5'd4;
    localparam logic [4:0] FPU_OP_SGNJ    = 5'd5;
    localparam logic [4:0] FPU_OP_SGNJN   = 5'd6;
    localparam logic [4:0] FPU_OP_SGNJX   = 5'd7;
    localparam logic [4:0] FPU_OP_MIN     = 5'd8;
    localparam logic [4:0] FPU_OP_MAX     = 5'd9;
    localparam logic [4:0] FPU_OP_FEQ     = 5'd10;
    localparam logic [4:0] FPU_OP_FLT     = 5'd11;
    localparam logic [4:0] FPU_OP_FLE     = 5'd12;
    localparam logic [4:0] FPU_OP_CLASS   = 5'd13;
    localparam logic [4:0] FPU_OP_CVT_W_S = 5'd14;
    localparam logic [4:0] FPU_OP_CVT_S_W = 5'd15;
    localparam logic [4:0] FPU_OP_MV_X_W  = 5'd16;
    localparam logic [4:0] FPU_OP_MV_W_X  = 5'd17;

    function automatic fpu_unit_t fpu_unit_of(input logic [4:0] op);
        fpu_unit_t u;
        case (op)
            FPU_OP_ADD, FPU_OP_SUB:                      u = FPU_UNIT_ADD;
            FPU_OP_MUL:                                  u = FPU_UNIT_MUL;
            FPU_OP_DIV, FPU_OP_SQRT:                     u = FPU_UNIT_DIVSQRT;
            FPU_OP_SGNJ, FPU_OP_SGNJN, FPU_OP_SGNJX:     u = FPU_UNIT_SGN;
            FPU_OP_MIN, FPU_OP_MAX, FPU_OP_FEQ, FPU_OP_FLT,
            FPU_OP_FLE, FPU_OP_CLASS, FPU_OP_CVT_W_S,
            FPU_OP_CVT_S_W, FPU_OP_MV_X_W, FPU_OP_MV_W_X: u = FPU_UNIT_MISC;
            default:                                     u = FPU_UNIT_NONE;
        endcase
        return u;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_dispatch_order_fifo.sv
//------------------------------------------------------------------------------
// fpu_order_fifo : issue-order FIFO of unit tags with flush and head output.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpu_order_fifo
    import FPU_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fpu_unit_t                  i_tag,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output fpu_unit_t                  o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fpu_unit_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= FPU_UNIT_NONE;
            end
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_tag;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_dispatch.sv
//------------------------------------------------------------------------------
// fpu_dispatch : in-order op dispatcher and result arbiter for the FPU units.
// Optional perf counters enabled by defining FPU_DISPATCH_PERF_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpu_dispatch
    import FPU_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int N_UNITS = N_FPU_UNITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [4:0]             op,
    output logic [N_UNITS-1:0]     unit_valid,
    input  logic [N_UNITS-1:0]     unit_ready,
    input  logic [N_UNITS-1:0]     unit_res_valid,
    output logic [N_UNITS-1:0]     unit_res_ready,
    input  logic [32*N_UNITS-1:0]  unit_result,
    input  logic [5*N_UNITS-1:0]   unit_fflags,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [31:0]            float_out,
    output logic [4:0]             fflags_out,
    output logic                   illegal_op
`ifdef FPU_DISPATCH_PERF_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            busy_cycles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fpu_unit_t           w_sel;
    fpu_unit_t           w_head;
    logic                w_sel_ok;
    logic [N_UNITS-1:0]  w_sel_oh;
    logic [N_UNITS-1:0]  w_head_oh;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_res_data;
    logic [4:0]          w_res_flags;
    logic                r_illegal;

    assign w_sel    = fpu_unit_of(op);
    assign w_sel_ok = (w_sel != FPU_UNIT_NONE);

    // One-hot decodes; NONE maps to all-zero so it never steers a unit.
    always_comb begin
        w_sel_oh  = '0;
        w_head_oh = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            w_sel_oh[i]  = (int'(w_sel) == i);
            w_head_oh[i] = (int'(w_head) == i);
        end
    end

    assign ready_out  = !flush && !w_full && (!w_sel_ok || |(w_sel_oh & unit_ready));
    assign unit_valid = (valid_in && !flush && !w_full) ? w_sel_oh : '0;
    assign w_accept   = valid_in && ready_out;
    assign w_push     = w_accept && w_sel_ok;

    always_comb begin
        w_res_data  = '0;
        w_res_flags = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (w_head_oh[i]) begin
                w_res_data  = unit_result[32*i +: 32];
                w_res_flags = unit_fflags[5*i +: 5];
            end
        end
    end

    assign valid_out      = !w_empty && !flush && |(w_head_oh & unit_res_valid);
    assign float_out      = valid_out ? w_res_data : '0;
    assign fflags_out     = valid_out ? w_res_flags : '0;
    assign unit_res_ready = (ready_in && !w_empty && !flush) ? w_head_oh : '0;
    assign w_pop          = valid_out && ready_in;
    assign illegal_op     = r_illegal;

    fpu_order_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_push  (w_push),
        .i_tag   (w_sel),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_sel_ok;
        end
    end

`ifdef FPU_DISPATCH_PERF_EN
    // Counters survive flush so they reflect the whole run since reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            busy_cycles  <= '0;
        end else begin
            if (valid_in && !ready_out && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (!w_empty && (busy_cycles != '1)) begin
                busy_cycles <= busy_cycles + 1'b1;
            end
        end
    end
`endif

    logic w_unused;
    assign w_unused = ^w_count;

endmodule

`default_nettype wire
